tarot_card_drawer: RTL
======================

TAROT_CARD_DRAWER -- requirements
Module: tarot_card_drawer

Interface
REQ-001 Parameter SPREAD, 3, number of cards drawn per draw request (1..8).
REQ-002 Parameter NUM_CARDS, 78, deck size; card indices are 0..NUM_CARDS-1.
REQ-003 Parameter TIMEOUT, 1024, maximum cycles spent waiting on any single PRNG handshake phase.
REQ-004 clk  input  1  sole clock; all logic is on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 draw_req  input  1  single-cycle request to draw one spread.
REQ-007 prng_start  output  1  level request to the upstream Henon PRNG.
REQ-008 prng_done  input  1  upstream completion flag; stays high until prng_start drops.
REQ-009 prng_x  input  32  upstream Q1.31 x output; valid while prng_done=1.
REQ-010 prng_y  input  32  upstream Q1.31 y output; valid while prng_done=1.
REQ-011 card_valid  output  1  one-cycle strobe qualifying card_idx, card_rev and card_pos.
REQ-012 card_idx  output  7  drawn card index.
REQ-013 card_rev  output  1  1 = reversed orientation.
REQ-014 card_pos  output  3  position of the card within the spread (0-based).
REQ-015 spread_done  output  1  one-cycle strobe, coincident with the last card_valid.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 error  output  1  one-cycle strobe on handshake timeout.

Function
REQ-018 States: IDLE, REQ, MAP, PROBE, EMIT, WAIT_LO.
REQ-019 IDLE: when draw_req=1, the block clears the used-card bitmap (NUM_CARDS bits), sets pos=0 and moves to REQ; draw_req is ignored in every other state.
REQ-020 REQ: prng_start=1; when prng_done=1, the block captures prng_x/prng_y, drops prng_start next cycle and moves to MAP.
REQ-021 MAP: candidate index = (x[31:16] * NUM_CARDS) >> 16, computed with a 16x7 unsigned product of at least 23 bits, giving a result in 0..NUM_CARDS-1; rev = y[31]; the block then moves to PROBE.
REQ-022 PROBE: one bitmap check per cycle; if the candidate is used, the candidate advances by 1, wrapping from NUM_CARDS-1 to 0; if it is free, the block sets its bit and moves to EMIT. The block makes at most SPREAD-1 probe steps per card.
REQ-023 EMIT: card_valid=1 for exactly one cycle, with card_pos=pos. If pos==SPREAD-1, spread_done=1 in the same cycle and the next state is IDLE; otherwise pos increments and the next state is WAIT_LO.
REQ-024 WAIT_LO: prng_start=0; when prng_done=0, the block moves to REQ.
REQ-025 Minimum latency from prng_done high in REQ to card_valid is 3 cycles (capture, MAP, PROBE hit), plus 1 cycle per probe step.
REQ-026 Timeout: a cycle counter resets on entry to REQ and on entry to WAIT_LO. If it reaches TIMEOUT in either state, the block pulses error for 1 cycle, drives prng_start=0, moves to IDLE and emits no spread_done.
REQ-027 card_idx, card_rev and card_pos hold their last emitted values between strobes.
REQ-028 prng_start is registered and never asserts while prng_done=1 from the previous handshake.

Reset
REQ-029 With rst=1 at a clock edge: state=IDLE; prng_start, card_valid, spread_done, busy and error are 0; card_idx, card_rev and card_pos are 0; the bitmap, pos and the timeout counter are cleared.
REQ-030 Reset mid-spread abandons the spread without any strobe, and prng_start is low on the first cycle after reset.

Structure
REQ-031 Shared package tarot_pkg holds NUM_CARDS, the card-index width (7), the state encoding and the PRNG handshake constants.
REQ-032 One sub-module, tarot_card_map, is combinational and maps (x[31:16], y[31]) to (candidate index, rev) per REQ-021.

Verification
REQ-033 Basic draw: SPREAD=3; prng_x = 0x00000000, 0x80000000, 0xFFFF0000; y[31] = 0,1,0 -> cards 0/0, 39/1, 77/0 at pos 0,1,2; spread_done with the third card.
REQ-034 Collision: prng_x = 0x80000000 three times -> cards 39, 40, 41; the second card is delayed 1 cycle and the third is delayed 2 cycles versus the no-collision timing.
REQ-035 Wrap: prng_x = 0xFFFF0000 twice, then 0x00000000 -> cards 77, 0, 1.
REQ-036 Handshake: the model holds prng_done high for 5 extra cycles -> prng_start stays low until prng_done falls; exactly 3 PRNG requests per spread.
REQ-037 Timeout: prng_done is never asserted -> error pulses on cycle TIMEOUT (1024) after entering REQ; busy=0 the next cycle; no card_valid.
REQ-038 Reset and ignore: rst asserted after the first card_valid -> all outputs 0, prng_start low; a new draw_req then draws from a cleared bitmap; a draw_req while busy has no effect.

Source files
------------

// File: rtl/tarot_pkg.sv
// Shared constants and state encoding for the tarot card drawer.
// Also holds the widths used by the PRNG handshake.
package tarot_pkg;

    localparam int NUM_CARDS = 78;
    localparam int CARD_W    = 7;
    localparam int POS_W     = 3;

    // PRNG handshake: Q1.31 words, of which the top FRAC_W bits of x feed the mapper
    localparam int PRNG_W = 32;
    localparam int FRAC_W = 16;
    localparam int PROD_W = FRAC_W + CARD_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        MAP     = 3'd2,
        PROBE   = 3'd3,
        EMIT    = 3'd4,
        WAIT_LO = 3'd5
    } state_e;

endpackage

// File: rtl/tarot_card_map.sv
// Combinational scaling of a Q0.16 fraction onto the deck: idx = (x_hi * NUM_CARDS) >> 16.
// The sign bit of y selects the card orientation.
module tarot_card_map #(
    parameter int NUM_CARDS = tarot_pkg::NUM_CARDS
) (
    input  logic [tarot_pkg::FRAC_W-1:0] x_hi,
    input  logic                         y_msb,
    output logic [tarot_pkg::CARD_W-1:0] cand,
    output logic                         rev
);
    import tarot_pkg::*;

    logic [PROD_W-1:0] product;
    logic              unused_frac;

    assign product     = PROD_W'(x_hi) * PROD_W'(NUM_CARDS);
    assign cand        = product[PROD_W-1 -: CARD_W];
    assign rev         = y_msb;
    assign unused_frac = ^product[FRAC_W-1:0];

endmodule

// File: rtl/tarot_card_drawer.sv
// Draws SPREAD distinct cards per request from an upstream PRNG handshake,
// resolving repeats by linear probing over a used-card bitmap.
module tarot_card_drawer #(
    parameter int SPREAD    = 3,
    parameter int NUM_CARDS = tarot_pkg::NUM_CARDS,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         draw_req,
    output logic                         prng_start,
    input  logic                         prng_done,
    input  logic [31:0]                  prng_x,
    input  logic [31:0]                  prng_y,
    output logic                         card_valid,
    output logic [tarot_pkg::CARD_W-1:0] card_idx,
    output logic                         card_rev,
    output logic [tarot_pkg::POS_W-1:0]  card_pos,
    output logic                         spread_done,
    output logic                         busy,
    output logic                         error
);
    import tarot_pkg::*;

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_e               state, state_next;
    logic [NUM_CARDS-1:0] used;
    logic [POS_W-1:0]     pos;
    logic [CARD_W-1:0]    cand;
    logic                 cand_rev;
    logic [FRAC_W-1:0]    x_hi;
    logic                 y_msb;
    logic [TMR_W-1:0]     timer;
    logic [CARD_W-1:0]    map_idx;
    logic                 map_rev;
    logic                 handshake;
    logic                 timed_out;
    logic                 last_pos;
    logic                 unused_bits;

    assign handshake   = prng_start && prng_done;
    assign timed_out   = (timer == TMR_W'(TIMEOUT - 1));
    assign last_pos    = (pos == POS_W'(SPREAD - 1));
    assign unused_bits = ^{prng_x[FRAC_W-1:0], prng_y[PRNG_W-2:0]};

    tarot_card_map #(
        .NUM_CARDS (NUM_CARDS)
    ) u_map (
        .x_hi  (x_hi),
        .y_msb (y_msb),
        .cand  (map_idx),
        .rev   (map_rev)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block is given a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_next  = state;
        error       = 1'b0;
        busy        = (state != IDLE);
        card_valid  = (state == EMIT);
        spread_done = (state == EMIT) && last_pos;
        unique case (state)
            IDLE:    if (draw_req) state_next = REQ;
            REQ: begin
                if (handshake) begin
                    state_next = MAP;
                end else if (timed_out) begin
                    error      = 1'b1;
                    state_next = IDLE;
                end
            end
            MAP:     state_next = PROBE;
            PROBE:   if (!used[cand]) state_next = EMIT;
            EMIT:    state_next = last_pos ? IDLE : WAIT_LO;
            WAIT_LO: begin
                if (!prng_done) begin
                    state_next = REQ;
                end else if (timed_out) begin
                    error      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prng_start <= 1'b0;
            used       <= '0;
            pos        <= '0;
            cand       <= '0;
            cand_rev   <= 1'b0;
            x_hi       <= '0;
            y_msb      <= 1'b0;
            timer      <= '0;
            card_idx   <= '0;
            card_rev   <= 1'b0;
            card_pos   <= '0;
        end else begin
            // Start rises only once the previous done has been seen low, then holds until captured.
            prng_start <= (state_next == REQ) && (prng_start || !prng_done);

            if ((state_next == REQ && state != REQ) || (state_next == WAIT_LO && state != WAIT_LO))
                timer <= '0;
            else if (state == REQ || state == WAIT_LO)
                timer <= timer + TMR_W'(1);

            unique case (state)
                IDLE: begin
                    if (draw_req) begin
                        used <= '0;
                        pos  <= '0;
                    end
                end
                REQ: begin
                    if (handshake) begin
                        x_hi  <= prng_x[PRNG_W-1 -: FRAC_W];
                        y_msb <= prng_y[PRNG_W-1];
                    end
                end
                MAP: begin
                    cand     <= map_idx;
                    cand_rev <= map_rev;
                end
                PROBE: begin
                    if (used[cand]) begin
                        cand <= (cand == CARD_W'(NUM_CARDS - 1)) ? '0 : cand + CARD_W'(1);
                    end else begin
                        used[cand] <= 1'b1;
                        card_idx   <= cand;
                        card_rev   <= cand_rev;
                        card_pos   <= pos;
                    end
                end
                EMIT:    if (!last_pos) pos <= pos + POS_W'(1);
                default: ;
            endcase
        end
    end

endmodule
